// File: rtl/sequenciador_de_status_if.sv
// Channel bundle of the status sequencer: per-channel requests, shared
// durations and the decoded status lines.
interface sequenciador_de_status_if #(
  parameter int CANAIS    = 4,
  parameter int LARG_CONT = 8
);
  logic [CANAIS-1:0]    liga;
  logic [CANAIS-1:0]    disparo;
  logic [LARG_CONT-1:0] tempo_preparacao;
  logic [LARG_CONT-1:0] tempo_ataque;
  logic [CANAIS-1:0]    desligado;
  logic [CANAIS-1:0]    preparacao;
  logic [CANAIS-1:0]    pronto;
  logic [CANAIS-1:0]    ataque;
  logic [2*CANAIS-1:0]  estado;
  logic [CANAIS-1:0]    fim_ataque;
  logic                 algum_ataque;

  modport master (
    output liga, disparo, tempo_preparacao, tempo_ataque,
    input  desligado, preparacao, pronto, ataque, estado, fim_ataque, algum_ataque
  );

  modport slave (
    input  liga, disparo, tempo_preparacao, tempo_ataque,
    output desligado, preparacao, pronto, ataque, estado, fim_ataque, algum_ataque
  );
endinterface

// File: rtl/sequenciador_de_status.sv
// Multi-channel status sequencer: DESLIGADO -> PREPARACAO -> PRONTO -> ATAQUE
// with timed preparation/attack phases and a registered end-of-attack pulse.
module sequenciador_de_status #(
  parameter int CANAIS    = 4,
  parameter int LARG_CONT = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  sequenciador_de_status_if.slave  bus
);

  // State codes double as the {A,B} status code seen downstream.
  localparam logic [1:0] DESLIGADO  = 2'b00;
  localparam logic [1:0] PREPARACAO = 2'b10;
  localparam logic [1:0] ATAQUE     = 2'b11;
  localparam logic [1:0] PRONTO     = 2'b01;

  localparam logic [LARG_CONT-1:0] UM = LARG_CONT'(1);

  logic [1:0]           estado_q [CANAIS];
  logic [LARG_CONT-1:0] cont_q   [CANAIS];
  logic [CANAIS-1:0]    fim_q;

  // NOTE: state is updated with <= so every channel sees the pre-edge values of
  // its own registers; blocking assignments here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CANAIS; i++) begin
        estado_q[i] <= DESLIGADO;
        cont_q[i]   <= '0;
      end
      fim_q <= '0;
    end else begin
      for (int i = 0; i < CANAIS; i++) begin
        fim_q[i] <= 1'b0;
        if (!bus.liga[i]) begin
          // Dropping the enable aborts any phase; cont is left as is.
          estado_q[i] <= DESLIGADO;
        end else begin
          case (estado_q[i])
            DESLIGADO: begin
              estado_q[i] <= PREPARACAO;
              cont_q[i]   <= bus.tempo_preparacao;
            end
            PREPARACAO: begin
              if (cont_q[i] == '0) estado_q[i] <= PRONTO;
              else                 cont_q[i]   <= cont_q[i] - UM;
            end
            PRONTO: begin
              if (bus.disparo[i]) begin
                estado_q[i] <= ATAQUE;
                cont_q[i]   <= bus.tempo_ataque;
              end
            end
            default: begin // ATAQUE
              if (cont_q[i] == '0) begin
                estado_q[i] <= PREPARACAO;
                cont_q[i]   <= bus.tempo_preparacao;
                fim_q[i]    <= 1'b1;
              end else begin
                cont_q[i] <= cont_q[i] - UM;
              end
            end
          endcase
        end
      end
    end
  end

  logic [CANAIS-1:0]   desligado_d;
  logic [CANAIS-1:0]   preparacao_d;
  logic [CANAIS-1:0]   pronto_d;
  logic [CANAIS-1:0]   ataque_d;
  logic [2*CANAIS-1:0] estado_d;

  // NOTE: every output of this block gets a default before the loop, so no
  // path through it leaves a value unassigned and no latch is inferred.
  always_comb begin
    desligado_d  = '0;
    preparacao_d = '0;
    pronto_d     = '0;
    ataque_d     = '0;
    estado_d     = '0;
    for (int i = 0; i < CANAIS; i++) begin
      estado_d[2*i +: 2] = estado_q[i];
      desligado_d[i]     = (estado_q[i] == DESLIGADO);
      preparacao_d[i]    = (estado_q[i] == PREPARACAO);
      pronto_d[i]        = (estado_q[i] == PRONTO);
      ataque_d[i]        = (estado_q[i] == ATAQUE);
    end
  end

  assign bus.desligado    = desligado_d;
  assign bus.preparacao   = preparacao_d;
  assign bus.pronto       = pronto_d;
  assign bus.ataque       = ataque_d;
  assign bus.estado       = estado_d;
  assign bus.fim_ataque   = fim_q;
  assign bus.algum_ataque = |ataque_d;

endmodule

// File: tb/tb_sequenciador_de_status.sv
// Directed bench for sequenciador_de_status: reset, nominal walk, abort,
// zero-duration loop, mid-phase duration change and async reset.
module tb_sequenciador_de_status;

  logic clk;
  logic clk_en;
  logic rst_n;
  int   total;
  int   bad;

  sequenciador_de_status_if #(.CANAIS(4), .LARG_CONT(8)) bus ();

  sequenciador_de_status #(.CANAIS(4), .LARG_CONT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.liga    = 4'h0;
    bus.disparo = 4'h0;
    step();
    total++;
    if (bus.desligado !== 4'hF) begin
      bad++;
      $display("FAIL idle_all desligado got=%h want=f", bus.desligado);
    end
  endtask

  task automatic test_reset();
    clk_en               = 1'b0;
    rst_n                = 1'b0;
    bus.liga             = 4'h0;
    bus.disparo          = 4'h0;
    bus.tempo_preparacao = 8'd0;
    bus.tempo_ataque     = 8'd0;
    #3;
    total++;
    if (bus.desligado !== 4'hF || bus.estado !== 8'h00) begin
      bad++;
      $display("FAIL reset_state desligado=%h estado=%h want f/00", bus.desligado, bus.estado);
    end
    total++;
    if (bus.preparacao !== 4'h0 || bus.pronto !== 4'h0 || bus.ataque !== 4'h0 ||
        bus.fim_ataque !== 4'h0 || bus.algum_ataque !== 1'b0) begin
      bad++;
      $display("FAIL reset_others prep=%h pronto=%h ataque=%h fim=%h algum=%b want 0",
               bus.preparacao, bus.pronto, bus.ataque, bus.fim_ataque, bus.algum_ataque);
    end
    clk_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    bus.tempo_preparacao = 8'd3;
    bus.tempo_ataque     = 8'd2;
    bus.liga             = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (bus.estado !== 8'b00_00_00_10) begin
        bad++;
        $display("FAIL nominal_prep cyc=%0d estado got=%h want=02", k, bus.estado);
      end
    end
    step();
    total++;
    if (bus.pronto !== 4'b0001 || bus.estado !== 8'h01) begin
      bad++;
      $display("FAIL nominal_pronto pronto=%h estado=%h want 1/01", bus.pronto, bus.estado);
    end
    bus.disparo = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      bus.disparo = 4'b0000;
      total++;
      if (bus.estado !== 8'h03 || bus.algum_ataque !== 1'b1 || bus.fim_ataque !== 4'h0) begin
        bad++;
        $display("FAIL nominal_ataque cyc=%0d estado=%h algum=%b fim=%h want 03/1/0",
                 k, bus.estado, bus.algum_ataque, bus.fim_ataque);
      end
    end
    step();
    total++;
    if (bus.fim_ataque !== 4'b0001 || bus.estado !== 8'h02) begin
      bad++;
      $display("FAIL nominal_fim fim=%h estado=%h want 1/02", bus.fim_ataque, bus.estado);
    end
    step();
    total++;
    if (bus.fim_ataque !== 4'h0 || bus.estado !== 8'h02) begin
      bad++;
      $display("FAIL nominal_fim_once fim=%h estado=%h want 0/02", bus.fim_ataque, bus.estado);
    end
  endtask

  task automatic test_abort();
    bus.tempo_preparacao = 8'd0;
    bus.tempo_ataque     = 8'd1;
    bus.liga             = 4'b0100;
    bus.disparo          = 4'b0100;
    step();  // PREPARACAO
    step();  // PRONTO
    step();  // ATAQUE, cont=1
    bus.disparo = 4'b0000;
    step();  // ATAQUE, cont=0 (final cycle)
    total++;
    if (bus.estado !== 8'h30) begin
      bad++;
      $display("FAIL abort_pre estado got=%h want=30", bus.estado);
    end
    bus.liga = 4'b0000;
    step();
    total++;
    if (bus.desligado !== 4'hF || bus.fim_ataque !== 4'h0 || bus.algum_ataque !== 1'b0) begin
      bad++;
      $display("FAIL abort desligado=%h fim=%h algum=%b want f/0/0",
               bus.desligado, bus.fim_ataque, bus.algum_ataque);
    end
  endtask

  task automatic test_zero_loop();
    logic [7:0] exp_est [9];
    logic [3:0] exp_fim [9];
    exp_est = '{8'hAA, 8'h55, 8'hFF, 8'hAA, 8'h55, 8'hFF, 8'hAA, 8'h55, 8'hFF};
    exp_fim = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
    bus.tempo_preparacao = 8'd0;
    bus.tempo_ataque     = 8'd0;
    bus.liga             = 4'hF;
    bus.disparo          = 4'hF;
    for (int k = 0; k < 9; k++) begin
      step();
      total++;
      if (bus.estado !== exp_est[k] || bus.fim_ataque !== exp_fim[k] ||
          bus.algum_ataque !== (exp_est[k] == 8'hFF)) begin
        bad++;
        $display("FAIL zero_loop cyc=%0d estado=%h fim=%h algum=%b want %h/%h",
                 k, bus.estado, bus.fim_ataque, bus.algum_ataque, exp_est[k], exp_fim[k]);
      end
    end
  endtask

  task automatic test_mid_change();
    int n;
    bus.tempo_preparacao = 8'd10;
    bus.liga             = 4'b0010;
    step();
    bus.tempo_preparacao = 8'd1;
    n = 0;
    while (bus.preparacao[1] === 1'b1 && n < 40) begin
      n++;
      step();
    end
    total++;
    if (n != 11) begin
      bad++;
      $display("FAIL mid_change prep_cycles got=%0d want=11", n);
    end
    total++;
    if (bus.pronto !== 4'b0010) begin
      bad++;
      $display("FAIL mid_change_pronto pronto got=%h want=2", bus.pronto);
    end
  endtask

  task automatic test_async_reset();
    int n;
    bus.tempo_preparacao = 8'd0;
    bus.tempo_ataque     = 8'd255;
    bus.liga             = 4'b1000;
    bus.disparo          = 4'b1000;
    step();
    step();
    step();
    bus.disparo = 4'b0000;
    for (int k = 0; k < 5; k++) step();
    total++;
    if (bus.ataque !== 4'b1000) begin
      bad++;
      $display("FAIL async_pre ataque got=%h want=8", bus.ataque);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.desligado !== 4'hF || bus.ataque !== 4'h0 || bus.fim_ataque !== 4'h0) begin
      bad++;
      $display("FAIL async_reset desligado=%h ataque=%h fim=%h want f/0/0",
               bus.desligado, bus.ataque, bus.fim_ataque);
    end
    bus.tempo_preparacao = 8'd20;
    step();
    #2;
    rst_n = 1'b1;
    step();
    n = 0;
    while (bus.preparacao[3] === 1'b1 && n < 60) begin
      n++;
      step();
    end
    total++;
    if (n != 21) begin
      bad++;
      $display("FAIL async_restart prep_cycles got=%0d want=21", n);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_nominal();
    idle_all();
    test_abort();
    idle_all();
    test_zero_loop();
    idle_all();
    test_mid_change();
    idle_all();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequenciador_de_status.md
# sequenciador_de_status

Parametrised multi-channel status sequencer: each of `CANAIS` independent channels walks DESLIGADO → PREPARACAO → PRONTO → ATAQUE under a per-channel enable and fire request, with programmable preparation and attack durations. It produces the one-hot per-channel status lines consumed by the panel and actuator logic, and the 2-bit {A,B} status code used by downstream status decoders. It adds timed phases, a new PRONTO state, abort handling and end-of-attack events.

## Interface
- `CANAIS`, default 4: number of independent channels (≥1).
- `LARG_CONT`, default 8: width of the duration inputs and the per-channel down-counters.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `liga`  in  CANAIS  per-channel enable request (level).
- `disparo`  in  CANAIS  per-channel fire request (level, sampled only in PRONTO).
- `tempo_preparacao`  in  LARG_CONT  preparation duration, shared by all channels.
- `tempo_ataque`  in  LARG_CONT  attack duration, shared by all channels.
- `desligado`  out  CANAIS  channel i is in DESLIGADO.
- `preparacao`  out  CANAIS  channel i is in PREPARACAO.
- `pronto`  out  CANAIS  channel i is in PRONTO.
- `ataque`  out  CANAIS  channel i is in ATAQUE.
- `estado`  out  2*CANAIS  {A,B} code of channel i at bits [2i+1:2i].
- `fim_ataque`  out  CANAIS  one-cycle pulse when channel i completes an attack normally.
- `algum_ataque`  out  1  OR of `ataque`.

## Operation
- State encoding, which is also the `estado` value {A,B}: DESLIGADO=00, PREPARACAO=10, ATAQUE=11, PRONTO=01.
- Each channel has a 2-bit state register and a `LARG_CONT`-bit down-counter `cont`. Channels never interact.
- Transitions per channel, evaluated every edge. `liga[i]`=0 has top priority in every state.
  - DESLIGADO: `liga`=1 → PREPARACAO, `cont` ← `tempo_preparacao`.
  - PREPARACAO: `liga`=0 → DESLIGADO. Else if `cont`==0 → PRONTO. Else `cont` ← `cont`−1.
  - PRONTO: `liga`=0 → DESLIGADO. Else if `disparo`=1 → ATAQUE, `cont` ← `tempo_ataque`. Else hold.
  - ATAQUE: `liga`=0 → DESLIGADO (abort, no `fim_ataque`). Else if `cont`==0 → PREPARACAO, `cont` ← `tempo_preparacao`, `fim_ataque` pulses. Else `cont` ← `cont`−1.
- Durations are sampled only on phase entry. Changing `tempo_*` mid-phase has no effect on the running phase.
- `disparo` is ignored in DESLIGADO, PREPARACAO and ATAQUE. A `disparo` held high across a return to PRONTO re-fires immediately (auto-repeat).
- `cont` holds its value in DESLIGADO and PRONTO. Its value there is don't-care, but it must not underflow.
- One-hot outputs and `estado` are combinational decodes of the state register only. Exactly one of `desligado`/`preparacao`/`pronto`/`ataque` is high per channel at all times.
- `fim_ataque` is a registered output, high for exactly one cycle, aligned with the first cycle of the following PREPARACAO.

## Timing
- Reset (asynchronous assert, release synchronous to `clk`): every channel DESLIGADO, `cont`=0, `desligado`=all 1, `preparacao`=`pronto`=`ataque`=0, `estado`=0, `fim_ataque`=0, `algum_ataque`=0.
- Reset asserted mid-phase forces DESLIGADO immediately, without waiting for a clock edge. No `fim_ataque` is generated.
- Latency: an input sampled at edge k is reflected in the outputs after edge k. There is no extra pipeline stage.
- PREPARACAO lasts exactly `tempo_preparacao`+1 cycles. `tempo_preparacao`=0 gives 1 cycle.
- ATAQUE lasts exactly `tempo_ataque`+1 cycles. Maximum is 2^LARG_CONT cycles.
- Minimum full loop with `liga`=1 held, `disparo`=1 held and both times 0: DESLIGADO(1), PREPARACAO(1), PRONTO(1), ATAQUE(1), then PREPARACAO. `fim_ataque` pulses every 3 cycles thereafter.
- If `liga` falls in the same cycle as the `cont`==0 expiry, DESLIGADO wins and `fim_ataque` stays 0.

## Test plan
- Reset check: assert `rst_n`=0 with no clock running → `desligado`=4'b1111, `estado`=8'h00, all other outputs 0.
- Nominal sequence on channel 0 with `tempo_preparacao`=3, `tempo_ataque`=2: raise `liga[0]` → 4 cycles PREPARACAO, then PRONTO. Pulse `disparo[0]` → 3 cycles ATAQUE (`estado[1:0]`=11), then `fim_ataque[0]` for 1 cycle and PREPARACAO. Channels 1–3 stay 00.
- Abort: drop `liga[2]` on the final ATAQUE cycle → channel 2 goes to DESLIGADO next edge, `fim_ataque[2]`=0.
- Zero durations with `liga`=`disparo`=4'b1111 held → all channels show period-3 PREPARACAO/PRONTO/ATAQUE, and `fim_ataque` pulses every 3 cycles.
- Mid-phase duration change: set `tempo_preparacao`=10 → 1 during PREPARACAO → the phase still lasts 11 cycles.
- Async reset in ATAQUE with `tempo_ataque`=255 → immediate DESLIGADO. After release and `liga`=1, PREPARACAO restarts with a full count.
